// File: rtl/smiley_collision_detector.sv
// smiley_collision_detector: per-source collision pulses with frame holdoff, frame masks and hit counter
module smiley_collision_detector #(
  parameter int HOLDOFF_FRAMES = 2,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   pause,
  input  logic                   reset_level,
  input  logic                   draw_smiley,
  input  logic                   draw_border_top,
  input  logic                   draw_border_left,
  input  logic                   draw_border_right,
  input  logic                   draw_flipper,
  input  logic                   draw_obstacle,
  output logic                   collisionSmileyBorderTop,
  output logic                   collisionSmileyBorderLeft,
  output logic                   collisionSmileyBorderRight,
  output logic                   collisionSmileyFlipper,
  output logic                   collisionSmileyObstacle,
  output logic [4:0]             frameCollisionMask,
  output logic [4:0]             lastFrameMask,
  output logic [COUNT_WIDTH-1:0] collisionCount
);
  localparam int HW = HOLDOFF_FRAMES > 0 ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HLOAD = HW'(HOLDOFF_FRAMES);
  typedef enum logic [1:0] {ARMED, FIRED, HOLDOFF} state_t;
  state_t st [5];
  state_t st_nx [5];
  logic [HW-1:0] hcnt [5];
  logic [HW-1:0] hcnt_nx [5];
  logic [4:0] overlap, fire, pulse, fmask, lmask;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH:0] sum;
  logic clr;
  assign overlap = {5{draw_smiley}} & {draw_obstacle, draw_flipper, draw_border_right, draw_border_left, draw_border_top};
  assign clr = !resetN || reset_level;
  assign sum = {1'b0, count} + (COUNT_WIDTH + 1)'($countones(fire));
  assign {collisionSmileyObstacle, collisionSmileyFlipper, collisionSmileyBorderRight, collisionSmileyBorderLeft, collisionSmileyBorderTop} = pulse;
  assign frameCollisionMask = fmask;
  assign lastFrameMask = lmask;
  assign collisionCount = count;
  // frame transition first, then overlap checked against the post-transition state
  always_comb begin
    fire = '0;
    for (int i = 0; i < 5; i++) begin
      st_nx[i] = st[i];
      hcnt_nx[i] = hcnt[i];
      if (!pause) begin
        if (startOfFrame && st[i] == FIRED) begin
          st_nx[i] = HOLDOFF_FRAMES == 0 ? ARMED : HOLDOFF;
          hcnt_nx[i] = HLOAD;
        end else if (startOfFrame && st[i] == HOLDOFF) begin
          st_nx[i] = hcnt[i] == HW'(1) ? ARMED : HOLDOFF;
          hcnt_nx[i] = hcnt[i] - HW'(1);
        end
        fire[i] = st_nx[i] == ARMED && overlap[i];
        if (fire[i]) st_nx[i] = FIRED;
      end
    end
  end
  // state, pulse, mask and saturating counter registers
  always_ff @(posedge clk) begin
    if (clr) begin
      st <= '{default: ARMED};
      hcnt <= '{default: '0};
      pulse <= '0;
      fmask <= '0;
      lmask <= '0;
      count <= '0;
    end else begin
      st <= st_nx;
      hcnt <= hcnt_nx;
      pulse <= fire;
      fmask <= startOfFrame ? fire : fmask | fire;
      lmask <= startOfFrame ? fmask : lmask;
      count <= sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_smiley_collision_detector.sv
// tb_smiley_collision_detector: directed self-checking bench for smiley_collision_detector
module tb_smiley_collision_detector;
  logic clk = 0, resetN = 0, startOfFrame = 0, pause = 0, reset_level = 0;
  logic draw_smiley = 0, draw_border_top = 0, draw_border_left = 0, draw_border_right = 0;
  logic draw_flipper = 0, draw_obstacle = 0;
  logic c_top, c_left, c_right, c_flip, c_obst;
  logic [4:0] fmask, lmask;
  logic [3:0] count;
  logic [4:0] pulses;
  int n_cmp = 0, n_err = 0;
  assign pulses = {c_obst, c_flip, c_right, c_left, c_top};

  smiley_collision_detector #(.HOLDOFF_FRAMES(2), .COUNT_WIDTH(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause), .reset_level(reset_level),
    .draw_smiley(draw_smiley), .draw_border_top(draw_border_top), .draw_border_left(draw_border_left),
    .draw_border_right(draw_border_right), .draw_flipper(draw_flipper), .draw_obstacle(draw_obstacle),
    .collisionSmileyBorderTop(c_top), .collisionSmileyBorderLeft(c_left),
    .collisionSmileyBorderRight(c_right), .collisionSmileyFlipper(c_flip),
    .collisionSmileyObstacle(c_obst), .frameCollisionMask(fmask), .lastFrameMask(lmask),
    .collisionCount(count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1;
    cyc();
    startOfFrame = 0;
  endtask

  task automatic set_draw(input logic [4:0] d);
    draw_smiley = |d;
    {draw_obstacle, draw_flipper, draw_border_right, draw_border_left, draw_border_top} = d;
  endtask

  task automatic clear_all();
    set_draw(5'b0);
    pause = 0;
    startOfFrame = 0;
    reset_level = 0;
    resetN = 0;
    cyc();
    resetN = 1;
  endtask

  task automatic test_reset();
    clear_all();
    n_cmp++; if (pulses !== 5'b0) begin n_err++; $display("FAIL reset_pulses: got %b expected %b", pulses, 5'b0); end
    n_cmp++; if (fmask !== 5'b0) begin n_err++; $display("FAIL reset_fmask: got %b expected %b", fmask, 5'b0); end
    n_cmp++; if (lmask !== 5'b0) begin n_err++; $display("FAIL reset_lmask: got %b expected %b", lmask, 5'b0); end
    n_cmp++; if (count !== 4'h0) begin n_err++; $display("FAIL reset_count: got %h expected %h", count, 4'h0); end
    set_draw(5'b01000);
    cyc();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b01000) begin n_err++; $display("FAIL reset_prefire: got %b expected %b", pulses, 5'b01000); end
    sof();
    n_cmp++; if (lmask !== 5'b01000) begin n_err++; $display("FAIL reset_presnap: got %b expected %b", lmask, 5'b01000); end
    cyc();
    resetN = 0;
    set_draw(5'b01000);
    cyc();
    resetN = 1;
    n_cmp++; if ({pulses, fmask, lmask, count} !== 19'b0) begin n_err++; $display("FAIL reset_midframe: got %h expected %h", {pulses, fmask, lmask, count}, 19'b0); end
    cyc();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b01000) begin n_err++; $display("FAIL reset_rearmed: got %b expected %b", pulses, 5'b01000); end
    n_cmp++; if (count !== 4'h1) begin n_err++; $display("FAIL reset_rearm_count: got %h expected %h", count, 4'h1); end
  endtask

  task automatic test_flipper_run();
    int first;
    int npulse;
    clear_all();
    first = -1;
    npulse = 0;
    set_draw(5'b01000);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (c_flip) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    set_draw(5'b0);
    n_cmp++; if (npulse !== 1) begin n_err++; $display("FAIL run_pulses: got %0d expected %0d", npulse, 1); end
    n_cmp++; if (first !== 0) begin n_err++; $display("FAIL run_latency: got %0d expected %0d", first, 0); end
    n_cmp++; if (count !== 4'h1) begin n_err++; $display("FAIL run_count: got %h expected %h", count, 4'h1); end
    n_cmp++; if (fmask !== 5'b01000) begin n_err++; $display("FAIL run_fmask: got %b expected %b", fmask, 5'b01000); end
  endtask

  task automatic test_holdoff();
    int exp_p [5] = '{1, 0, 0, 1, 0};
    int np;
    clear_all();
    for (int f = 0; f < 5; f++) begin
      if (f > 0) sof();
      np = 0;
      set_draw(5'b01000);
      for (int k = 0; k < 5; k++) begin
        cyc();
        if (c_flip) np++;
      end
      set_draw(5'b0);
      n_cmp++; if (np !== exp_p[f]) begin n_err++; $display("FAIL holdoff_frame%0d: got %0d expected %0d", f, np, exp_p[f]); end
    end
    n_cmp++; if (count !== 4'h2) begin n_err++; $display("FAIL holdoff_count: got %h expected %h", count, 4'h2); end
  endtask

  task automatic test_sof_overlap();
    clear_all();
    set_draw(5'b01000);
    cyc();
    set_draw(5'b0);
    sof();
    sof();
    set_draw(5'b01000);
    sof();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b01000) begin n_err++; $display("FAIL sofov_pulse: got %b expected %b", pulses, 5'b01000); end
    n_cmp++; if (lmask !== 5'b0) begin n_err++; $display("FAIL sofov_lmask: got %b expected %b", lmask, 5'b0); end
    n_cmp++; if (fmask !== 5'b01000) begin n_err++; $display("FAIL sofov_fmask: got %b expected %b", fmask, 5'b01000); end
  endtask

  task automatic test_simultaneous();
    clear_all();
    set_draw(5'b00011);
    cyc();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b00011) begin n_err++; $display("FAIL simul_pulses: got %b expected %b", pulses, 5'b00011); end
    n_cmp++; if (count !== 4'h2) begin n_err++; $display("FAIL simul_count: got %h expected %h", count, 4'h2); end
    n_cmp++; if (fmask !== 5'b00011) begin n_err++; $display("FAIL simul_fmask: got %b expected %b", fmask, 5'b00011); end
    sof();
    n_cmp++; if (lmask !== 5'b00011) begin n_err++; $display("FAIL simul_lmask: got %b expected %b", lmask, 5'b00011); end
    n_cmp++; if (fmask !== 5'b0) begin n_err++; $display("FAIL simul_fclr: got %b expected %b", fmask, 5'b0); end
  endtask

  task automatic test_pause();
    int np;
    clear_all();
    set_draw(5'b01000);
    cyc();
    pause = 1;
    set_draw(5'b01001);
    np = 0;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        np += $countones(pulses);
      end
      sof();
      np += $countones(pulses);
    end
    n_cmp++; if (np !== 0) begin n_err++; $display("FAIL pause_pulses: got %0d expected %0d", np, 0); end
    n_cmp++; if (count !== 4'h1) begin n_err++; $display("FAIL pause_count: got %h expected %h", count, 4'h1); end
    n_cmp++; if (fmask !== 5'b0) begin n_err++; $display("FAIL pause_fmask: got %b expected %b", fmask, 5'b0); end
    pause = 0;
    cyc();
    n_cmp++; if (pulses !== 5'b00001) begin n_err++; $display("FAIL pause_release: got %b expected %b", pulses, 5'b00001); end
    sof();
    n_cmp++; if (pulses !== 5'b0) begin n_err++; $display("FAIL pause_sof1: got %b expected %b", pulses, 5'b0); end
    cyc();
    sof();
    n_cmp++; if (pulses !== 5'b0) begin n_err++; $display("FAIL pause_sof2: got %b expected %b", pulses, 5'b0); end
    cyc();
    sof();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b01001) begin n_err++; $display("FAIL pause_sof3: got %b expected %b", pulses, 5'b01001); end
    n_cmp++; if (count !== 4'h4) begin n_err++; $display("FAIL pause_count_end: got %h expected %h", count, 4'h4); end
  endtask

  task automatic test_saturate();
    int hits;
    clear_all();
    hits = 0;
    set_draw(5'b11111);
    for (int f = 0; f < 10; f++) begin
      startOfFrame = (f > 0);
      cyc();
      startOfFrame = 0;
      hits += $countones(pulses);
      if (f == 0) begin
        n_cmp++; if (count !== 4'h5) begin n_err++; $display("FAIL sat_first: got %h expected %h", count, 4'h5); end
      end
      cyc();
      hits += $countones(pulses);
      cyc();
      hits += $countones(pulses);
    end
    set_draw(5'b0);
    n_cmp++; if (hits !== 20) begin n_err++; $display("FAIL sat_hits: got %0d expected %0d", hits, 20); end
    n_cmp++; if (count !== 4'hF) begin n_err++; $display("FAIL sat_count: got %h expected %h", count, 4'hF); end
    reset_level = 1;
    cyc();
    reset_level = 0;
    n_cmp++; if (count !== 4'h0) begin n_err++; $display("FAIL lvl_count: got %h expected %h", count, 4'h0); end
    n_cmp++; if ({fmask, lmask} !== 10'b0) begin n_err++; $display("FAIL lvl_masks: got %h expected %h", {fmask, lmask}, 10'b0); end
    set_draw(5'b10000);
    cyc();
    set_draw(5'b0);
    n_cmp++; if (pulses !== 5'b10000) begin n_err++; $display("FAIL lvl_rearm: got %b expected %b", pulses, 5'b10000); end
  endtask

  initial begin
    test_reset();
    test_flipper_run();
    test_holdoff();
    test_sof_overlap();
    test_simultaneous();
    test_pause();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
